hls_macc_initiator: RTL and testbench
=====================================

HLS_MACC_INITIATOR -- requirements
Module: hls_macc_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles from core_start assertion to core_done before abort; legal range 4..65535.
REQ-002 SHALL have parameter DATA_W, default 32: width of each operand and result word.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_valid, input, 1 bit: operand bundle valid.
REQ-006 SHALL have port s_ready, output, 1 bit: operand bundle accepted.
REQ-007 SHALL have port s_data, input, 5*DATA_W bits: operand bundle {i6,i4,i3,i2,i1}, i1 in the LSBs.
REQ-008 SHALL have port m_valid, output, 1 bit: result valid.
REQ-009 SHALL have port m_ready, input, 1 bit: result accepted.
REQ-010 SHALL have port m_o1, output, DATA_W bits: captured o1.
REQ-011 SHALL have port m_o2, output, DATA_W bits: captured o2.
REQ-012 SHALL have port m_err, output, 1 bit: result produced by a timeout, not by core completion.
REQ-013 SHALL have port core_start, output, 1 bit: ap_start to the accelerator.
REQ-014 SHALL have ports core_done, core_idle and core_ready, each input, 1 bit: ap_done, ap_idle and ap_ready from the accelerator.
REQ-015 SHALL have ports core_i1, core_i2, core_i3, core_i4 and core_i6, each output, DATA_W bits: operands to the accelerator.
REQ-016 SHALL have ports core_o1 and core_o2, each input, DATA_W bits; and core_o1_vld and core_o2_vld, each input, 1 bit: accelerator results and their valid strobes.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, OUT, one-hot encoded.
REQ-018 In IDLE: s_ready=1; when s_valid&s_ready, SHALL latch s_data into core_i* and move to RUN the next cycle.
REQ-019 In RUN: core_start=1 until core_ready is sampled high, then 0 (ap_ctrl_hs); core_i* SHALL stay stable throughout RUN.
REQ-020 In RUN: core_o1_vld high SHALL capture core_o1 into m_o1; core_o2_vld high SHALL capture core_o2 into m_o2; core_done sampled high SHALL move the FSM to OUT with m_err=0.
REQ-021 core_done, core_ready and a vld strobe in the same cycle: all captures SHALL take effect in that cycle, then the FSM moves to OUT.
REQ-022 A vld strobe without core_done SHALL capture but not change state; strobes outside RUN SHALL be ignored.
REQ-023 In OUT: m_valid=1, with m_o1, m_o2 and m_err held; m_valid&m_ready SHALL return the FSM to IDLE; s_ready=0 in RUN and OUT (one transaction in flight).
REQ-024 Latency: accept at cycle N -> core_start at N+1 -> m_valid the cycle after core_done is sampled.
REQ-025 A result with no vld strobe seen SHALL report the zeros loaded at accept.
REQ-026 m_o1 and m_o2 SHALL be cleared to 0 on each accept.

Reset
REQ-027 ap_rst_n low SHALL asynchronously force IDLE, s_ready=0 during reset, m_valid=0, m_err=0, core_start=0, m_o1=m_o2=0, core_i*=0 and timeout counter=0.
REQ-028 Reset mid-RUN SHALL drop core_start the same cycle; the in-flight result SHALL be discarded.
REQ-029 s_ready SHALL first be 1 in the first clock after ap_rst_n deasserts.

Configuration
REQ-030 With HLS_MACC_INITIATOR_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-031 With HLS_MACC_INITIATOR_TIMEOUT_EN defined: at count==TIMEOUT_CYCLES-1 without core_done, the FSM SHALL go to OUT with m_err=1 and core_start=0.
REQ-032 With HLS_MACC_INITIATOR_TIMEOUT_EN defined: core_done in the terminal cycle SHALL win, with m_err=0.
REQ-033 Without HLS_MACC_INITIATOR_TIMEOUT_EN: no counter SHALL exist, m_err SHALL be tied to 0, and RUN SHALL wait indefinitely.

Structure
REQ-034 Package hls_macc_pkg SHALL hold the FSM state typedef, the DATA_W default and the operand bundle field offsets.
REQ-035 Sub-module hls_macc_timeout (counter plus compare) SHALL be instantiated only under the macro.

Verification
REQ-036 Model core: done/ready 3 cycles after start, o1=0x12345678, o2=0x9ABCDEF0 -> m_valid 5 cycles after accept, m_o1 and m_o2 equal those values, m_err=0.
REQ-037 m_ready held low 10 cycles in OUT -> outputs stable, s_ready=0; the s_valid bundle offered in that time is accepted only after the m handshake.
REQ-038 Core never asserts done, macro on, TIMEOUT_CYCLES=8 -> m_valid with m_err=1, m_o1=m_o2=0, core_start low at the abort.
REQ-039 done, ready and both vld strobes in one cycle -> single capture, m_valid next cycle.
REQ-040 ap_rst_n pulsed low in RUN cycle 2 -> core_start=0 immediately, no m_valid, next bundle runs normally.
REQ-041 Back-to-back bundles with m_ready=1 -> each result matches its own operands, no drops or duplicates.

Source files
------------

// File: rtl/hls_macc_initiator_pkg.sv
// hls_macc_pkg: shared types and constants for the HLS MACC initiator.
//   state_t   : one-hot FSM state encoding (IDLE, RUN, OUT)
//   DATA_W_DEF: default operand/result word width
//   I*_OFS    : word offsets of each operand inside the s_data bundle
//               {i6,i4,i3,i2,i1}, i1 in the LSBs
package hls_macc_pkg;

  localparam int DATA_W_DEF = 32;

  localparam int I1_OFS = 0;
  localparam int I2_OFS = 1;
  localparam int I3_OFS = 2;
  localparam int I4_OFS = 3;
  localparam int I6_OFS = 4;
  localparam int N_OPND = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_OUT  = 3'b100
  } state_t;

endpackage

// File: rtl/hls_macc_initiator_if.sv
// hls_macc_initiator_if: operand-in / result-out handshake bundle.
//   s_valid, s_ready, s_data       : operand bundle stream (5*DATA_W bits)
//   m_valid, m_ready, m_o1, m_o2, m_err : result stream
// Modports: slave  = the initiator (consumes operands, produces results)
//           master = the environment driving operands and taking results
interface hls_macc_initiator_if
  import hls_macc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                       s_valid;
  logic                       s_ready;
  logic [N_OPND*DATA_W-1:0]   s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_W-1:0]          m_o1;
  logic [DATA_W-1:0]          m_o2;
  logic                       m_err;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_o1, m_o2, m_err
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_o1, m_o2, m_err
  );
endinterface

// File: rtl/hls_macc_initiator_timeout.sv
// hls_macc_timeout: 16-bit RUN-cycle counter with terminal-count compare.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   clr              : zero the counter (entry to RUN)
//   en               : count this cycle (FSM in RUN)
//   hit              : count has reached TIMEOUT_CYCLES-1
// Only instantiated when HLS_MACC_INITIATOR_TIMEOUT_EN is defined.
module hls_macc_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam logic [15:0] TC = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign hit = (cnt_q == TC);
endmodule

// File: rtl/hls_macc_initiator.sv
// hls_macc_initiator: drives one HLS accelerator (ap_ctrl_hs) per operand
// bundle and returns the captured o1/o2 results.
//   ap_clk, ap_rst_n     : clock, async active-low reset
//   bus (slave)          : operand stream in, result stream out
//   core_start           : ap_start to the accelerator
//   core_done/idle/ready : ap_done / ap_idle / ap_ready from the accelerator
//   core_i1..i4, core_i6 : operands held stable for the whole RUN phase
//   core_o1/o2 (+_vld)   : accelerator results and their strobes
// Optional: define HLS_MACC_INITIATOR_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYCLES cycles with m_err=1; otherwise RUN waits indefinitely and
// m_err is tied low.
//
// state | meaning
// IDLE  | s_ready high, waiting for an operand bundle
// RUN   | operands applied, ap_start held until ap_ready, capturing strobes
// OUT   | result presented on m_*, waiting for m_ready
module hls_macc_initiator
  import hls_macc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = DATA_W_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  hls_macc_initiator_if.slave  bus,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic                 core_idle,
  input  logic                 core_ready,
  output logic [DATA_W-1:0]    core_i1,
  output logic [DATA_W-1:0]    core_i2,
  output logic [DATA_W-1:0]    core_i3,
  output logic [DATA_W-1:0]    core_i4,
  output logic [DATA_W-1:0]    core_i6,
  input  logic [DATA_W-1:0]    core_o1,
  input  logic [DATA_W-1:0]    core_o2,
  input  logic                 core_o1_vld,
  input  logic                 core_o2_vld
);
  state_t                    state_q;
  logic                      s_ready_q;
  logic                      start_q;
  logic                      m_valid_q;
  logic [DATA_W-1:0]         o1_q;
  logic [DATA_W-1:0]         o2_q;
  logic [N_OPND*DATA_W-1:0]  opnd_q;
  logic                      accept;

  // ap_ready/ap_done fully sequence the handshake; ap_idle carries no extra info.
  logic unused_core_idle;
  assign unused_core_idle = core_idle;

  assign accept = (state_q == ST_IDLE) && bus.s_valid && s_ready_q;

`ifdef HLS_MACC_INITIATOR_TIMEOUT_EN
  logic timeout_hit;
  logic m_err_q;

  hls_macc_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (accept),
    .en       (state_q == ST_RUN),
    .hit      (timeout_hit)
  );

  assign bus.m_err = m_err_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign bus.m_err = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      m_valid_q <= 1'b0;
      o1_q      <= '0;
      o2_q      <= '0;
      opnd_q    <= '0;
`ifdef HLS_MACC_INITIATOR_TIMEOUT_EN
      m_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            opnd_q    <= bus.s_data;
            o1_q      <= '0;
            o2_q      <= '0;
            start_q   <= 1'b1;
            s_ready_q <= 1'b0;
            state_q   <= ST_RUN;
          end else begin
            // s_ready rises on the first clock out of reset and after each result.
            s_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_o1_vld) o1_q <= core_o1;
          if (core_o2_vld) o2_q <= core_o2;
          if (core_ready)  start_q <= 1'b0;
          // core_done has priority over the timeout in the terminal cycle.
          if (core_done) begin
            start_q   <= 1'b0;
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
`ifdef HLS_MACC_INITIATOR_TIMEOUT_EN
            m_err_q   <= 1'b0;
          end else if (timeout_hit) begin
            start_q   <= 1'b0;
            m_valid_q <= 1'b1;
            m_err_q   <= 1'b1;
            state_q   <= ST_OUT;
`endif
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          start_q   <= 1'b0;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_o1    = o1_q;
  assign bus.m_o2    = o2_q;
  assign core_start  = start_q;

  assign core_i1 = opnd_q[I1_OFS*DATA_W +: DATA_W];
  assign core_i2 = opnd_q[I2_OFS*DATA_W +: DATA_W];
  assign core_i3 = opnd_q[I3_OFS*DATA_W +: DATA_W];
  assign core_i4 = opnd_q[I4_OFS*DATA_W +: DATA_W];
  assign core_i6 = opnd_q[I6_OFS*DATA_W +: DATA_W];
endmodule

// File: tb/tb_hls_macc_initiator.sv
// Directed testbench for hls_macc_initiator.
module tb_hls_macc_initiator;
  localparam int DW = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          core_start;
  logic          core_done, core_idle, core_ready;
  logic [DW-1:0] core_i1, core_i2, core_i3, core_i4, core_i6;
  logic [DW-1:0] core_o1, core_o2;
  logic          core_o1_vld, core_o2_vld;

  int n_assert = 0;
  int n_fail   = 0;

  hls_macc_initiator_if #(.DATA_W(DW)) bus ();

  hls_macc_initiator #(
    .TIMEOUT_CYCLES(8),
    .DATA_W(DW)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .bus         (bus.slave),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_idle   (core_idle),
    .core_ready  (core_ready),
    .core_i1     (core_i1),
    .core_i2     (core_i2),
    .core_i3     (core_i3),
    .core_i4     (core_i4),
    .core_i6     (core_i6),
    .core_o1     (core_o1),
    .core_o2     (core_o2),
    .core_o1_vld (core_o1_vld),
    .core_o2_vld (core_o2_vld)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [DW-1:0] i1, input logic [DW-1:0] i2,
                       input logic [DW-1:0] i3, input logic [DW-1:0] i4,
                       input logic [DW-1:0] i6);
    bus.s_data  = {i6, i4, i3, i2, i1};
    bus.s_valid = 1'b1;
  endtask

  // One full transaction with m_ready high; core returns o1=i1+i2, o2=i3^i4^i6.
  task automatic txn(input logic [DW-1:0] i1, input logic [DW-1:0] i2,
                     input logic [DW-1:0] i3, input logic [DW-1:0] i4,
                     input logic [DW-1:0] i6);
    logic [DW-1:0] e1, e2;
    e1 = i1 + i2;
    e2 = i3 ^ i4 ^ i6;
    chk1("b2b_s_ready", bus.s_ready, 1'b1);
    offer(i1, i2, i3, i4, i6);
    tick();
    bus.s_valid = 1'b0;
    chk32("b2b_core_i1", core_i1, i1);
    chk32("b2b_core_i6", core_i6, i6);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    chk1("b2b_start_drop", core_start, 1'b0);
    core_o1 = e1; core_o1_vld = 1'b1;
    core_o2 = e2; core_o2_vld = 1'b1;
    core_done = 1'b1;
    tick();
    core_o1_vld = 1'b0; core_o2_vld = 1'b0; core_done = 1'b0;
    chk1("b2b_m_valid", bus.m_valid, 1'b1);
    chk32("b2b_m_o1", bus.m_o1, e1);
    chk32("b2b_m_o2", bus.m_o2, e2);
    tick();
    chk1("b2b_no_dup", bus.m_valid, 1'b0);
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    core_done   = 1'b0;
    core_idle   = 1'b1;
    core_ready  = 1'b0;
    core_o1     = '0;
    core_o2     = '0;
    core_o1_vld = 1'b0;
    core_o2_vld = 1'b0;

    // Reset state
    tick(); tick();
    chk1("rst_s_ready", bus.s_ready, 1'b0);
    chk1("rst_m_valid", bus.m_valid, 1'b0);
    chk1("rst_m_err", bus.m_err, 1'b0);
    chk1("rst_core_start", core_start, 1'b0);
    chk32("rst_m_o1", bus.m_o1, 32'h0);
    chk32("rst_core_i1", core_i1, 32'h0);
    ap_rst_n = 1'b1;
    #1;
    chk1("rel_s_ready_before_clk", bus.s_ready, 1'b0);
    tick();
    chk1("rel_s_ready_first_clk", bus.s_ready, 1'b1);

    // Basic transaction; done, ready and both strobes land in one cycle
    offer(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h66666666);
    tick();
    bus.s_valid = 1'b0;
    chk1("a_core_start", core_start, 1'b1);
    chk1("a_s_ready", bus.s_ready, 1'b0);
    chk32("a_core_i1", core_i1, 32'h11111111);
    chk32("a_core_i2", core_i2, 32'h22222222);
    chk32("a_core_i3", core_i3, 32'h33333333);
    chk32("a_core_i4", core_i4, 32'h44444444);
    chk32("a_core_i6", core_i6, 32'h66666666);
    tick(); tick(); tick();
    chk1("a_m_valid_early", bus.m_valid, 1'b0);
    chk1("a_start_held", core_start, 1'b1);
    chk32("a_core_i3_stable", core_i3, 32'h33333333);
    core_done = 1'b1; core_ready = 1'b1;
    core_o1 = 32'h12345678; core_o1_vld = 1'b1;
    core_o2 = 32'h9ABCDEF0; core_o2_vld = 1'b1;
    tick();
    core_done = 1'b0; core_ready = 1'b0; core_o1_vld = 1'b0; core_o2_vld = 1'b0;
    chk1("a_m_valid", bus.m_valid, 1'b1);
    chk32("a_m_o1", bus.m_o1, 32'h12345678);
    chk32("a_m_o2", bus.m_o2, 32'h9ABCDEF0);
    chk1("a_m_err", bus.m_err, 1'b0);
    chk1("a_start_low", core_start, 1'b0);

    // Back-pressure in OUT; a new bundle waits, stray strobes ignored
    offer(32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0006);
    core_o1 = 32'hDEADBEEF; core_o1_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("bp_m_valid", bus.m_valid, 1'b1);
      chk32("bp_m_o1", bus.m_o1, 32'h12345678);
      chk32("bp_m_o2", bus.m_o2, 32'h9ABCDEF0);
      chk1("bp_s_ready", bus.s_ready, 1'b0);
      chk32("bp_core_i1", core_i1, 32'h11111111);
    end
    core_o1_vld = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk1("bp_m_valid_drop", bus.m_valid, 1'b0);
    chk1("bp_s_ready_back", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    chk32("bp_new_i1", core_i1, 32'hAAAA0001);
    chk32("bp_new_i6", core_i6, 32'hAAAA0006);
    chk32("clr_m_o1", bus.m_o1, 32'h0);
    chk32("clr_m_o2", bus.m_o2, 32'h0);
    chk1("bp_start", core_start, 1'b1);

    // Separate ready, o1 strobe without done, then done alone
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    chk1("sep_start_drop", core_start, 1'b0);
    chk1("sep_m_valid0", bus.m_valid, 1'b0);
    core_o1 = 32'hA5A5A5A5; core_o1_vld = 1'b1;
    tick();
    core_o1_vld = 1'b0;
    chk32("sep_o1_capture", bus.m_o1, 32'hA5A5A5A5);
    chk1("sep_no_state_change", bus.m_valid, 1'b0);
    core_o2 = 32'h77777777;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk1("sep_m_valid", bus.m_valid, 1'b1);
    chk32("sep_m_o1", bus.m_o1, 32'hA5A5A5A5);
    chk32("sep_m_o2_zero", bus.m_o2, 32'h0);
    chk1("sep_m_err", bus.m_err, 1'b0);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk1("sep_done", bus.m_valid, 1'b0);

    // Reset pulsed in RUN cycle 2
    offer(32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003, 32'h0BAD0004, 32'h0BAD0006);
    tick();
    bus.s_valid = 1'b0;
    tick();
    chk1("rr_start_before", core_start, 1'b1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk1("rr_start_now", core_start, 1'b0);
    chk1("rr_m_valid", bus.m_valid, 1'b0);
    chk1("rr_s_ready", bus.s_ready, 1'b0);
    chk32("rr_core_i1", core_i1, 32'h0);
    #1;
    ap_rst_n = 1'b1;
    core_done = 1'b1; core_o1 = 32'h55555555; core_o1_vld = 1'b1;
    tick();
    core_done = 1'b0; core_o1_vld = 1'b0;
    chk1("rr_no_m_valid", bus.m_valid, 1'b0);
    chk32("rr_idle_ignore_o1", bus.m_o1, 32'h0);
    chk1("rr_s_ready_after", bus.s_ready, 1'b1);

    // Back-to-back bundles with m_ready high
    bus.m_ready = 1'b1;
    txn(32'h00000010, 32'h00000020, 32'h000000F0, 32'h0000000F, 32'h00000100);
    txn(32'hFFFFFFFF, 32'h00000001, 32'h12345678, 32'h87654321, 32'h0F0F0F0F);
    txn(32'h7FFFFFFF, 32'h7FFFFFFF, 32'hCAFEBABE, 32'h00000000, 32'hFFFFFFFF);
    bus.m_ready = 1'b0;

`ifdef HLS_MACC_INITIATOR_TIMEOUT_EN
    // Core never finishes: abort after 8 RUN cycles
    offer(32'h1, 32'h2, 32'h3, 32'h4, 32'h6);
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk1("to_not_yet", bus.m_valid, 1'b0);
    chk1("to_start_held", core_start, 1'b1);
    tick();
    chk1("to_m_valid", bus.m_valid, 1'b1);
    chk1("to_m_err", bus.m_err, 1'b1);
    chk1("to_start_low", core_start, 1'b0);
    chk32("to_m_o1", bus.m_o1, 32'h0);
    chk32("to_m_o2", bus.m_o2, 32'h0);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;

    // core_done in the terminal cycle wins
    offer(32'h1, 32'h2, 32'h3, 32'h4, 32'h6);
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk1("tc_m_valid", bus.m_valid, 1'b1);
    chk1("tc_m_err", bus.m_err, 1'b0);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
